// File: rtl/cnn_pkg.sv
// Shared types and sizes for the CNN datapath (convolution -> relu/pool -> dense).
// Pure declarations, no logic.
// Frame sizes here are the defaults the pooling stage is built for.
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int CONV_W = 30;
  localparam int POOL_W = CONV_W / 2;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef pix_t [CONV_W*CONV_W-1:0] conv_frame_t;
endpackage

// File: rtl/max4_relu.sv
// Signed max of a 2x2 window followed by ReLU clamp.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module max4_relu
  import cnn_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic signed [W-1:0] i_p0,
  input  logic signed [W-1:0] i_p1,
  input  logic signed [W-1:0] i_p2,
  input  logic signed [W-1:0] i_p3,
  output logic signed [W-1:0] o_max
);

  logic signed [W-1:0] w_m01;
  logic signed [W-1:0] w_m23;
  logic signed [W-1:0] w_m;

  // Two-level signed compare tree, then clamp negatives to zero.
  always_comb begin
    w_m01 = (i_p0 > i_p1) ? i_p0 : i_p1;
    w_m23 = (i_p2 > i_p3) ? i_p2 : i_p3;
    w_m   = (w_m01 > w_m23) ? w_m01 : w_m23;
    o_max = w_m[W-1] ? '0 : w_m;
  end

endmodule

// File: rtl/relu_maxpool_stream.sv
// Captures a full convolved frame, streams 2x2/stride-2 max-pooled ReLU pixels row-major.
// Latency: first beat valid 1 cycle after frame capture; one beat per cycle thereafter.
// Backpressure: out_valid/out_ready; data, last and counters hold while stalled.
module relu_maxpool_stream #(
  parameter int IN_W   = cnn_pkg::CONV_W,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_W*IN_W-1:0][DATA_W-1:0] frame_in,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last
);

  localparam int OUT_W = IN_W / 2;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int IW    = $clog2(IN_W * IN_W);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]                      r_state;
  logic [IN_W*IN_W-1:0][DATA_W-1:0] r_frame;
  logic [CW-1:0]                   r_row;
  logic [CW-1:0]                   r_col;
  logic [DATA_W-1:0]               r_out_data;
  logic                            r_out_valid;
  logic                            r_out_last;

  logic                     w_capture;
  logic                     w_xfer;
  logic                     w_wrap;
  logic [CW-1:0]            w_row_nx;
  logic [CW-1:0]            w_col_nx;
  logic                     w_last_nx;
  logic [IW-1:0]            w_base;
  logic signed [DATA_W-1:0] w_p0;
  logic signed [DATA_W-1:0] w_p1;
  logic signed [DATA_W-1:0] w_p2;
  logic signed [DATA_W-1:0] w_p3;
  logic signed [DATA_W-1:0] w_pool;

  assign frame_ready = (r_state == S_IDLE);
  assign w_capture   = frame_ready && frame_valid;
  assign w_xfer      = r_out_valid && out_ready;

  // Next (row,col) after the beat currently presented; row wraps too so the window index stays in range.
  always_comb begin
    w_wrap   = (r_col == CW'(OUT_W - 1));
    w_col_nx = w_wrap ? '0 : r_col + CW'(1);
    w_row_nx = r_row;
    if (w_wrap) begin
      w_row_nx = (r_row == CW'(OUT_W - 1)) ? '0 : r_row + CW'(1);
    end
    w_last_nx = (w_row_nx == CW'(OUT_W - 1)) && (w_col_nx == CW'(OUT_W - 1));
    w_base    = IW'(2 * IN_W) * IW'(w_row_nx) + IW'({w_col_nx, 1'b0});
  end

  // Window mux: on capture the frame register is not loaded yet, so window (0,0) comes straight from frame_in.
  always_comb begin
    if (w_capture) begin
      w_p0 = frame_in[0];
      w_p1 = frame_in[1];
      w_p2 = frame_in[IN_W];
      w_p3 = frame_in[IN_W + 1];
    end else begin
      w_p0 = r_frame[w_base];
      w_p1 = r_frame[w_base + IW'(1)];
      w_p2 = r_frame[w_base + IW'(IN_W)];
      w_p3 = r_frame[w_base + IW'(IN_W + 1)];
    end
  end

  max4_relu #(
    .W (DATA_W)
  ) u_max4_relu (
    .i_p0  (w_p0),
    .i_p1  (w_p1),
    .i_p2  (w_p2),
    .i_p3  (w_p3),
    .o_max (w_pool)
  );

  // Frame buffer: contents are don't-care until a capture, so no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_frame <= frame_in;
    end
  end

  // FSM, pooled-map counters and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (frame_valid) begin
        r_state     <= S_STREAM;
        r_row       <= '0;
        r_col       <= '0;
        r_out_data  <= w_pool;
        r_out_valid <= 1'b1;
        r_out_last  <= (OUT_W == 1);
      end
    end else if (w_xfer) begin
      if (r_out_last) begin
        r_state     <= S_IDLE;
        r_row       <= '0;
        r_col       <= '0;
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_row      <= w_row_nx;
        r_col      <= w_col_nx;
        r_out_data <= w_pool;
        r_out_last <= w_last_nx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
